// File: rtl/sparse_stream_loader.sv
// sparse_stream_loader: on-chip store of per-channel compressed values and
// zero-run indices, streamed to a PE as LANES-wide beats under valid/ready
// back-pressure with per-channel and whole-transfer last markers.
module sparse_stream_loader #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int LANES  = 4,
    parameter int MAX_CH = 4,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(MAX_CH)-1:0]   wr_ch,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic                        start,
    input  logic [MAX_CH-1:0]           ch_mask,
    input  logic [MAX_CH*CNT_W-1:0]     cfg_count,
    input  logic                        abort,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [LANES*DATA_W-1:0]     out_data,
    output logic [LANES*IDX_W-1:0]      out_idx,
    output logic [LANES-1:0]            out_lane_vld,
    output logic [$clog2(MAX_CH)-1:0]   out_ch,
    output logic                        out_last_ch,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CH_W  = $clog2(MAX_CH);
    localparam int AW    = $clog2(DEPTH);
    localparam int AD_W  = CNT_W + 1;
    localparam int ENT_W = DATA_W + IDX_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(MAX_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        STREAM,
        DRAIN
    } state_t;

    // Entry {value, index}; channel c, address a lives at {c, a}.
    logic [ENT_W-1:0] mem [MAX_CH*DEPTH];

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [AD_W-1:0]             addr_q, addr_d;
    logic [MAX_CH-1:0]           mask_q, mask_d;
    logic [MAX_CH*CNT_W-1:0]     count_q, count_d;
    logic                        out_valid_q, out_valid_d;
    logic [LANES*DATA_W-1:0]     out_data_q, out_data_d;
    logic [LANES*IDX_W-1:0]      out_idx_q, out_idx_d;
    logic [LANES-1:0]            out_lane_vld_q, out_lane_vld_d;
    logic [CH_W-1:0]             out_ch_q, out_ch_d;
    logic                        out_last_ch_q, out_last_ch_d;
    logic                        out_last_q, out_last_d;
    logic                        done_q, done_d;

    logic [CNT_W-1:0]            cur_count;
    logic [MAX_CH-1:0]           active;
    logic                        later_active;
    logic [LANES*DATA_W-1:0]     beat_data;
    logic [LANES*IDX_W-1:0]      beat_idx;
    logic [LANES-1:0]            beat_vld;
    logic                        beat_last_ch;

    // Load port; only accepted while idle so a running transfer sees frozen contents.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[{wr_ch, wr_addr}] <= {wr_data, wr_idx};
        end
    end

    // Channel activity and the candidate beat at the current channel/address.
    always_comb begin
        logic [AD_W-1:0]  lane_addr;
        logic [ENT_W-1:0] entry;
        cur_count    = count_q[ch_q*CNT_W +: CNT_W];
        active       = '0;
        later_active = 1'b0;
        beat_data    = '0;
        beat_idx     = '0;
        beat_vld     = '0;
        lane_addr    = '0;
        entry        = '0;
        for (int j = 0; j < MAX_CH; j++) begin
            active[j] = mask_q[j] && (count_q[j*CNT_W +: CNT_W] != '0);
        end
        for (int j = 0; j < MAX_CH; j++) begin
            if ((CH_W'(j) > ch_q) && active[j]) begin
                later_active = 1'b1;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            lane_addr = addr_q + AD_W'(l);
            if (lane_addr < AD_W'(cur_count)) begin
                entry                         = mem[{ch_q, lane_addr[AW-1:0]}];
                beat_vld[l]                   = 1'b1;
                beat_data[l*DATA_W +: DATA_W] = entry[ENT_W-1:IDX_W];
                beat_idx[l*IDX_W +: IDX_W]    = entry[IDX_W-1:0];
            end
        end
        beat_last_ch = (addr_q + AD_W'(LANES)) >= AD_W'(cur_count);
    end

    // Next-state, counters and output-register loading.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        addr_d         = addr_q;
        mask_d         = mask_q;
        count_d        = count_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        out_lane_vld_d = out_lane_vld_q;
        out_ch_d       = out_ch_q;
        out_last_ch_d  = out_last_ch_q;
        out_last_d     = out_last_q;
        done_d         = 1'b0;

        if ((state_q != IDLE) && abort) begin
            state_d        = IDLE;
            ch_d           = '0;
            addr_d         = '0;
            out_valid_d    = 1'b0;
            out_data_d     = '0;
            out_idx_d      = '0;
            out_lane_vld_d = '0;
            out_ch_d       = '0;
            out_last_ch_d  = 1'b0;
            out_last_d     = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d = ch_mask;
                        for (int c = 0; c < MAX_CH; c++) begin
                            count_d[c*CNT_W +: CNT_W] =
                                (cfg_count[c*CNT_W +: CNT_W] > CNT_W'(DEPTH)) ?
                                CNT_W'(DEPTH) : cfg_count[c*CNT_W +: CNT_W];
                        end
                        ch_d    = '0;
                        addr_d  = '0;
                        state_d = SEEK;
                    end
                end
                SEEK: begin
                    if (active[ch_q]) begin
                        state_d = STREAM;
                    end else if (ch_q == LAST_CH) begin
                        state_d = DRAIN;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                STREAM: begin
                    if (!out_valid_q || out_ready) begin
                        out_valid_d    = 1'b1;
                        out_data_d     = beat_data;
                        out_idx_d      = beat_idx;
                        out_lane_vld_d = beat_vld;
                        out_ch_d       = ch_q;
                        out_last_ch_d  = beat_last_ch;
                        out_last_d     = beat_last_ch && !later_active;
                        if (beat_last_ch) begin
                            addr_d = '0;
                            if (ch_q == LAST_CH) begin
                                state_d = DRAIN;
                            end else begin
                                ch_d    = ch_q + CH_W'(1);
                                state_d = SEEK;
                            end
                        end else begin
                            addr_d = addr_q + AD_W'(LANES);
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            addr_q         <= '0;
            mask_q         <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            out_lane_vld_q <= '0;
            out_ch_q       <= '0;
            out_last_ch_q  <= 1'b0;
            out_last_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            addr_q         <= addr_d;
            mask_q         <= mask_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_lane_vld_q <= out_lane_vld_d;
            out_ch_q       <= out_ch_d;
            out_last_ch_q  <= out_last_ch_d;
            out_last_q     <= out_last_d;
            done_q         <= done_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;
    assign out_lane_vld = out_lane_vld_q;
    assign out_ch       = out_ch_q;
    assign out_last_ch  = out_last_ch_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_sparse_stream_loader.sv
// Testbench for sparse_stream_loader: random memory image and handshakes,
// expected beats produced by a channel-by-channel reference model.
module tb_sparse_stream_loader;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;
    localparam int LANES  = 4;
    localparam int MAX_CH = 4;
    localparam int DEPTH  = 512;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CH_W   = $clog2(MAX_CH);
    localparam int AW     = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wr_en;
    logic [CH_W-1:0]          wr_ch;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [IDX_W-1:0]         wr_idx;
    logic                     start;
    logic [MAX_CH-1:0]        ch_mask;
    logic [MAX_CH*CNT_W-1:0]  cfg_count;
    logic                     abort;
    logic                     out_ready;
    logic                     out_valid;
    logic [LANES*DATA_W-1:0]  out_data;
    logic [LANES*IDX_W-1:0]   out_idx;
    logic [LANES-1:0]         out_lane_vld;
    logic [CH_W-1:0]          out_ch;
    logic                     out_last_ch;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    sparse_stream_loader #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .LANES(LANES),
        .MAX_CH(MAX_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data), .wr_idx(wr_idx),
        .start(start), .ch_mask(ch_mask), .cfg_count(cfg_count), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_lane_vld(out_lane_vld), .out_ch(out_ch), .out_last_ch(out_last_ch),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        logic [LANES*IDX_W-1:0]  idx;
        logic [LANES-1:0]        vld;
        logic [CH_W-1:0]         ch;
        logic                    lastCh;
        logic                    last;
    } beat_t;

    beat_t             expQ[$];
    logic [DATA_W-1:0] refData [MAX_CH][DEPTH];
    logic [IDX_W-1:0]  refIdx  [MAX_CH][DEPTH];
    int                numChecks = 0;
    int                numFails  = 0;
    int                expBubbles;
    int                expFirstValid;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [MAX_CH*CNT_W-1:0] cfgOf(input int c0, input int c1, input int c2, input int c3);
        logic [MAX_CH*CNT_W-1:0] v;
        v = {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        return v;
    endfunction

    // Reference: every enabled non-empty channel in order, ceil(count/LANES) beats each.
    function automatic void buildModel(input logic [MAX_CH-1:0] mask, input logic [MAX_CH*CNT_W-1:0] cfg);
        int    cnt [MAX_CH];
        int    lastActive = -1;
        int    prevActive = -1;
        int    nb;
        int    a;
        beat_t e;
        expQ.delete();
        expBubbles    = 0;
        expFirstValid = -1;
        for (int c = 0; c < MAX_CH; c++) begin
            cnt[c] = int'(cfg[c*CNT_W +: CNT_W]);
            if (cnt[c] > DEPTH) cnt[c] = DEPTH;
            if (mask[c] && cnt[c] > 0) lastActive = c;
        end
        for (int c = 0; c < MAX_CH; c++) begin
            if (mask[c] && cnt[c] > 0) begin
                if (prevActive < 0) expFirstValid = c + 2;
                else expBubbles += c - prevActive;
                prevActive = c;
                nb = (cnt[c] + LANES - 1) / LANES;
                for (int b = 0; b < nb; b++) begin
                    e = '0;
                    for (int l = 0; l < LANES; l++) begin
                        a = b * LANES + l;
                        if (a < cnt[c]) begin
                            e.data[l*DATA_W +: DATA_W] = refData[c][a];
                            e.idx[l*IDX_W +: IDX_W]    = refIdx[c][a];
                            e.vld[l]                   = 1'b1;
                        end
                    end
                    e.ch     = CH_W'(c);
                    e.lastCh = (b == nb - 1);
                    e.last   = e.lastCh && (c == lastActive);
                    expQ.push_back(e);
                end
            end
        end
    endfunction

    // Runs one transfer; abortAfter > 0 cancels after that many accepted beats.
    task automatic applyStimulus(input logic [MAX_CH-1:0] mask, input logic [MAX_CH*CNT_W-1:0] cfg,
                                 input int readyPct, input int abortAfter);
        int    accepted = 0;
        int    firstValid = -1;
        int    bubbles = 0;
        int    gap = 0;
        int    nBeats;
        bit    stalled = 0;
        bit    finished = 0;
        bit    doneSeen = 0;
        beat_t cur;
        beat_t held;
        beat_t e;
        held = '0;
        buildModel(mask, cfg);
        nBeats    = expQ.size();
        ch_mask   = mask;
        cfg_count = cfg;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4000 && !finished; k++) begin
            cur.data = out_data; cur.idx = out_idx; cur.vld = out_lane_vld;
            cur.ch = out_ch; cur.lastCh = out_last_ch; cur.last = out_last;
            if (abortAfter > 0) begin
                wr_en   = (k == 3);
                wr_ch   = '0;
                wr_addr = '0;
                wr_data = ~refData[0][0];
                wr_idx  = ~refIdx[0][0];
            end
            if (done) begin
                checkOutput("done busy low", busy, 0);
                checkOutput("done no valid", out_valid, 0);
                checkOutput("done beats left", expQ.size(), 0);
                if (nBeats == 0) checkOutput("empty done cycle", k, MAX_CH + 1);
                else if (readyPct >= 100) begin
                    checkOutput("first beat latency", firstValid, expFirstValid);
                    checkOutput("bubbles", bubbles, expBubbles);
                end
                doneSeen = 1;
                finished = 1;
            end else begin
                if (nBeats == 0 && k <= MAX_CH) checkOutput("empty busy", busy, 1);
                out_ready = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
                if (out_valid) begin
                    if (firstValid < 0) firstValid = k;
                    bubbles += gap;
                    gap = 0;
                    if (stalled) checkOutput("stall hold", cur, held);
                    stalled = !out_ready;
                    held    = cur;
                    if (out_ready) begin
                        if (expQ.size() == 0) checkOutput("extra beat", expQ.size(), 1);
                        else begin
                            e = expQ.pop_front();
                            checkOutput("beat data", cur.data, e.data);
                            checkOutput("beat idx", cur.idx, e.idx);
                            checkOutput("beat lane_vld", cur.vld, e.vld);
                            checkOutput("beat ch", cur.ch, e.ch);
                            checkOutput("beat last_ch", cur.lastCh, e.lastCh);
                            checkOutput("beat last", cur.last, e.last);
                        end
                        accepted++;
                        if (abortAfter > 0 && accepted == abortAfter) begin
                            @(posedge clk); #1;
                            wr_en = 1'b0;
                            checkOutput("busy before abort", busy, 1);
                            abort = 1'b1;
                            @(posedge clk); #1;
                            abort = 1'b0;
                            checkOutput("abort valid", out_valid, 0);
                            checkOutput("abort busy", busy, 0);
                            checkOutput("abort done", done, 0);
                            checkOutput("abort lane_vld", out_lane_vld, 0);
                            checkOutput("abort data", out_data, 0);
                            checkOutput("abort last", {out_last, out_last_ch}, 0);
                            for (int i = 0; i < 3; i++) begin
                                @(posedge clk); #1;
                                checkOutput("abort no done", done, 0);
                            end
                            finished = 1;
                        end
                    end
                end else begin
                    stalled = 0;
                    if (firstValid >= 0) gap++;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        wr_en = 1'b0;
        if (!finished) checkOutput("transfer timeout", doneSeen, 1);
        if (doneSeen) begin
            @(posedge clk); #1;
            checkOutput("done one pulse", done, 0);
        end
    endtask

    initial begin
        logic [MAX_CH-1:0] rmask;
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0; wr_idx = '0;
        start = 1'b0; ch_mask = '0; cfg_count = '0; abort = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("reset valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int c = 0; c < MAX_CH; c++) begin
            for (int a = 0; a < DEPTH; a++) begin
                refData[c][a] = DATA_W'($urandom);
                refIdx[c][a]  = IDX_W'($urandom);
                wr_en   = 1'b1;
                wr_ch   = CH_W'(c);
                wr_addr = AW'(a);
                wr_data = refData[c][a];
                wr_idx  = refIdx[c][a];
                @(posedge clk); #1;
            end
        end
        wr_en = 1'b0;

        $display("[TB] two channels, full throughput");
        applyStimulus(4'b0011, cfgOf(219, 220, 0, 0), 100, 0);
        $display("[TB] two channels, random back-pressure");
        applyStimulus(4'b0011, cfgOf(219, 220, 0, 0), 50, 0);
        $display("[TB] masked and empty channels skipped");
        applyStimulus(4'b1010, cfgOf(8, 0, 6, 5), 100, 0);
        $display("[TB] empty transfers");
        applyStimulus(4'b0000, cfgOf(10, 10, 10, 10), 100, 0);
        applyStimulus(4'b1111, cfgOf(0, 0, 0, 0), 100, 0);
        $display("[TB] abort and replay");
        applyStimulus(4'b0011, cfgOf(219, 220, 0, 0), 100, 10);
        applyStimulus(4'b0011, cfgOf(219, 220, 0, 0), 100, 0);
        $display("[TB] count clamp");
        applyStimulus(4'b0001, cfgOf(600, 0, 0, 0), 100, 0);
        $display("[TB] random transfers");
        for (int i = 0; i < 4; i++) begin
            rmask = MAX_CH'($urandom);
            applyStimulus(rmask, cfgOf($urandom_range(0, 40), $urandom_range(0, 40),
                                       $urandom_range(0, 40), $urandom_range(0, 40)), 70, 0);
        end

        $display("[TB] async reset mid-beat");
        out_ready = 1'b0;
        ch_mask   = 4'b0001;
        cfg_count = cfgOf(600, 0, 0, 0);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("valid before reset", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid", out_valid, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset data", out_data, 0);
        checkOutput("async reset lane_vld", out_lane_vld, 0);
        checkOutput("async reset last", {out_last, out_last_ch}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("after reset idle", {busy, out_valid, done}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
